// File: rtl/key_conditioner_pkg.sv
// Shared types and 50 MHz default timing for the push-button conditioning path.
package key_cond_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } kc_state_e;

    localparam int KC_DEBOUNCE_20MS      = 1_000_000;
    localparam int KC_REPEAT_DELAY_500MS = 25_000_000;
    localparam int KC_REPEAT_RATE_100MS  = 5_000_000;

    function automatic int kc_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Conditioned key outputs: debounced level plus press/release/repeat strobes.
interface key_conditioner_if;
    logic key_level;
    logic press_pulse;
    logic release_pulse;
    logic repeat_pulse;

    modport master (output key_level, press_pulse, release_pulse, repeat_pulse);
    modport slave  (input  key_level, press_pulse, release_pulse, repeat_pulse);
endinterface

// File: rtl/key_conditioner_sync_2ff.sv
// Two-flop synchroniser with a configurable reset value; reusable for switch inputs.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/key_conditioner.sv
// Synchronises and debounces one active-low board key; emits level, press/release
// strobes and an optional hold-to-repeat strobe.
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = KC_DEBOUNCE_20MS,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = KC_REPEAT_DELAY_500MS,
    parameter int REPEAT_RATE     = KC_REPEAT_RATE_100MS
) (
    input  logic                      CLOCK_50,
    input  logic                      RESET_N,
    input  logic                      KEY_N,
    key_conditioner_if.master         kc_o
);

    localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW  = $clog2(kc_max(REPEAT_DELAY, REPEAT_RATE) + 1);
    localparam int RW1 = RW + 1;
    localparam logic [CW-1:0] DEB_V   = DEBOUNCE_CYCLES[CW-1:0];
    localparam logic [RW:0]   DELAY_V = REPEAT_DELAY[RW:0];
    localparam logic [RW:0]   RATE_V  = REPEAT_RATE[RW:0];

    logic key_sync;
    logic key_s;

    sync_2ff #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync (
        .clk   (CLOCK_50),
        .rst_n (RESET_N),
        .d_i   (KEY_N),
        .q_o   (key_sync)
    );

    assign key_s = ~key_sync;

    kc_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [RW:0]   rcnt_inc;
    logic          phase_q, phase_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          repeat_q, repeat_d;
    logic          rep_run;
    logic          fire;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            RELEASED: begin
                if (key_s) begin
                    state_d = PRESS_PEND;
                    cnt_d   = CW'(1);
                end
            end
            PRESS_PEND: begin
                if (!key_s) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_V) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PRESSED: begin
                if (!key_s) begin
                    state_d = RELEASE_PEND;
                    cnt_d   = CW'(1);
                end
            end
            RELEASE_PEND: begin
                if (key_s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_V) begin
                    state_d   = RELEASED;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = RELEASED;
        endcase
    end

    // Repeat timing only advances while the key stays held across the edge; a fresh
    // press restarts it from zero because PRESS_PEND is never part of the held set.
    always_comb begin
        rep_run  = ((state_q == PRESSED) || (state_q == RELEASE_PEND)) &&
                   ((state_d == PRESSED) || (state_d == RELEASE_PEND));
        rcnt_inc = {1'b0, rcnt_q} + RW1'(1);
        fire     = rep_run && (rcnt_inc == (phase_q ? RATE_V : DELAY_V));
        rcnt_d   = '0;
        phase_d  = 1'b0;
        if (rep_run) begin
            rcnt_d  = fire ? '0 : rcnt_inc[RW-1:0];
            phase_d = phase_q | fire;
        end
        // A repeat that falls due while release is pending is dropped, not deferred.
        repeat_d = (REPEAT_EN != 0) && fire && (state_d == PRESSED);
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= RELEASED;
            cnt_q     <= '0;
            rcnt_q    <= '0;
            phase_q   <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rcnt_q    <= rcnt_d;
            phase_q   <= phase_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
        end
    end

    assign kc_o.key_level     = level_q;
    assign kc_o.press_pulse   = press_q;
    assign kc_o.release_pulse = release_q;
    assign kc_o.repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Randomised and directed stimulus for key_conditioner against a run-length reference model.
module tb_key_conditioner;

    localparam int D    = 4;
    localparam int DEL  = 10;
    localparam int RATE = 3;

    logic clk;
    logic RESET_N;
    logic KEY_N;

    key_conditioner_if kc_bus ();

    key_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_EN       (1),
        .REPEAT_DELAY    (DEL),
        .REPEAT_RATE     (RATE)
    ) dut (
        .CLOCK_50 (clk),
        .RESET_N  (RESET_N),
        .KEY_N    (KEY_N),
        .kc_o     (kc_bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference: raw key seen through two delay stages; level flips after D+1
    // consecutive synchronised samples disagree with it; repeats are hold-time arithmetic.
    logic m_s1, m_s2, m_lvl;
    int   m_run, m_hold;
    logic e_press, e_rel, e_rep;
    logic o_lvl, o_press, o_rel, o_rep;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 1'b1; m_s2 = 1'b1; m_lvl = 1'b0;
        m_run = 0; m_hold = 0;
        e_press = 1'b0; e_rel = 1'b0; e_rep = 1'b0;
    endtask

    task automatic model_edge();
        logic ks;
        if (!RESET_N) begin
            model_reset();
            return;
        end
        ks   = ~m_s2;
        m_s2 = m_s1;
        m_s1 = KEY_N;
        e_press = 1'b0; e_rel = 1'b0; e_rep = 1'b0;
        if (ks != m_lvl) begin
            m_run++;
            if (m_run == D + 1) begin
                m_lvl = ks;
                m_run = 0;
                if (ks) e_press = 1'b1;
                else    e_rel   = 1'b1;
            end
        end else begin
            m_run = 0;
        end
        if (e_press)    m_hold = 0;
        else if (m_lvl) m_hold++;
        else            m_hold = 0;
        if (m_lvl && !e_press && m_run == 0 && m_hold > 0 &&
            (m_hold == DEL || (m_hold > DEL && (m_hold - DEL) % RATE == 0)))
            e_rep = 1'b1;
    endtask

    task automatic tick(input logic k);
        KEY_N = k;
        @(posedge clk);
        model_edge();
        #1;
        o_lvl = kc_bus.key_level; o_press = kc_bus.press_pulse;
        o_rel = kc_bus.release_pulse; o_rep = kc_bus.repeat_pulse;
        check("key_level", int'(o_lvl),   int'(m_lvl));
        check("press",     int'(o_press), int'(e_press));
        check("release",   int'(o_rel),   int'(e_rel));
        check("repeat",    int'(o_rep),   int'(e_rep));
    endtask

    task automatic press_latency(input string tag);
        int lat;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick(1'b0);
            if (o_press) begin
                lat = i - 1;
                break;
            end
        end
        check(tag, lat, D + 2);
    endtask

    task automatic async_reset_check(input string tag);
        #3;
        RESET_N = 1'b0;
        model_reset();
        #1;
        check({tag, "_lvl"}, int'(kc_bus.key_level),     0);
        check({tag, "_prs"}, int'(kc_bus.press_pulse),   0);
        check({tag, "_rel"}, int'(kc_bus.release_pulse), 0);
        check({tag, "_rep"}, int'(kc_bus.repeat_pulse),  0);
    endtask

    initial begin
        int reps;
        int reached;
        RESET_N = 1'b0;
        KEY_N   = 1'b1;
        model_reset();
        repeat (3) tick(1'b1);
        RESET_N = 1'b1;

        repeat (50) tick(1'b1);

        press_latency("clean_press_lat");
        reps = 0;
        for (int k = 1; k <= 30; k++) begin
            tick(1'b0);
            if (o_rep) reps++;
        end
        check("repeat_count", reps, 7);

        repeat (2) tick(1'b1);
        repeat (12) tick(1'b0);
        check("glitch_level", int'(o_lvl), 1);
        repeat (12) tick(1'b1);

        repeat (3) tick(1'b0);
        repeat (2) tick(1'b1);
        press_latency("bounce_press_lat");
        repeat (12) tick(1'b1);

        for (int b = 0; b < 60; b++) begin
            logic v;
            int   len;
            v   = logic'($urandom_range(0, 1));
            len = int'($urandom_range(1, 12));
            repeat (len) tick(v);
        end
        repeat (12) tick(1'b1);

        repeat (12) tick(1'b0);
        async_reset_check("rst_pressed");
        repeat (2) tick(1'b1);
        RESET_N = 1'b1;
        repeat (5) tick(1'b1);

        reached = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0);
            if (m_run == 3 && !m_lvl) begin
                reached = 1;
                break;
            end
        end
        check("pend_reached", reached, 1);
        async_reset_check("rst_pend");
        repeat (2) tick(1'b0);
        RESET_N = 1'b1;
        press_latency("post_reset_press_lat");
        repeat (12) tick(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
